c17_top: RTL and testbench

Registered wrapper around the ISCAS-85 c17 benchmark netlist: five primary inputs, two primary outputs, six 2-input NAND gates. Inputs are captured in a register stage, evaluated through the fixed NAND netlist, and the results are registered before driving the outputs. It is the top-level DUT for gate-level benchmark flows (simulation, synthesis and VCD dumping) and uses a single clock domain.

---
 rtl/c17_pkg.sv | 26 ++
 rtl/c17_if.sv | 22 ++
 rtl/c17_comb.sv | 26 ++
 rtl/c17_nand2.sv | 9 +
 rtl/c17_top.sv | 45 ++++
 tb/tb_c17_top.sv | 128 ++++++++++++
 6 files changed

// File: rtl/c17_pkg.sv
// Shared types and constants for the registered c17 benchmark wrapper.
package c17_pkg;

  localparam int C17_NUM_IN  = 5;
  localparam int C17_NUM_OUT = 2;
  localparam int C17_LATENCY = 2;

  localparam logic [C17_NUM_IN-1:0]  C17_RST_IN  = 5'b0;
  localparam logic [C17_NUM_OUT-1:0] C17_RST_OUT = 2'b0;

  // Primary inputs, named after the original netlist nets, MSB = N1.
  typedef struct packed {
    logic n1;
    logic n2;
    logic n3;
    logic n6;
    logic n7;
  } c17_in_t;

  // Primary outputs, MSB = N22.
  typedef struct packed {
    logic po0;
    logic po1;
  } c17_out_t;

endpackage

// File: rtl/c17_if.sv
// Pin bundle of the c17 wrapper: five primary inputs, two registered outputs.
interface c17_if;
  logic input_0;
  logic input_1;
  logic input_2;
  logic input_3;
  logic input_4;
  logic po0;
  logic po1;

  // Stimulus side drives vectors and observes results.
  modport master (
    output input_0, input_1, input_2, input_3, input_4,
    input  po0, po1
  );

  // Design side consumes vectors and drives results.
  modport slave (
    input  input_0, input_1, input_2, input_3, input_4,
    output po0, po1
  );
endinterface

// File: rtl/c17_comb.sv
// Combinational ISCAS-85 c17 netlist: six explicit NAND2 instances,
// at most three gate levels from any input to any output.
module c17_comb (
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N6,
  input  logic N7,
  output logic N22,
  output logic N23
);
  logic w_n10;
  logic w_n11;
  logic w_n16;
  logic w_n19;

  // Level 1
  c17_nand2 u_g10 (.i_a(N1),    .i_b(N3),    .o_y(w_n10));
  c17_nand2 u_g11 (.i_a(N3),    .i_b(N6),    .o_y(w_n11));
  // Level 2
  c17_nand2 u_g16 (.i_a(N2),    .i_b(w_n11), .o_y(w_n16));
  c17_nand2 u_g19 (.i_a(w_n11), .i_b(N7),    .o_y(w_n19));
  // Level 3
  c17_nand2 u_g22 (.i_a(w_n10), .i_b(w_n16), .o_y(N22));
  c17_nand2 u_g23 (.i_a(w_n16), .i_b(w_n19), .o_y(N23));
endmodule

// File: rtl/c17_nand2.sv
// Two-input NAND leaf cell; kept as its own module so every gate of the
// netlist is a distinct instance for fault and benchmark tooling.
module c17_nand2 (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = ~(i_a & i_b);
endmodule

// File: rtl/c17_top.sv
// Registered c17 wrapper: input flops -> NAND netlist -> output flops.
// Two-edge latency, one vector per cycle, synchronous active-high reset.
// Reset values equal the netlist response to all-zero inputs, so the
// pipeline is self-consistent coming out of reset.
module c17_top
  import c17_pkg::*;
(
  input  logic clock,
  input  logic reset,
  c17_if.slave bus
);
  c17_in_t  r_in_q;
  c17_out_t r_out;
  c17_in_t  w_in;
  logic     w_n22;
  logic     w_n23;

  assign w_in = '{n1: bus.input_0, n2: bus.input_1, n3: bus.input_2,
                  n6: bus.input_3, n7: bus.input_4};

  // Stage 1: capture the primary inputs; reset wins over capture.
  always_ff @(posedge clock) begin
    if (reset) r_in_q <= c17_in_t'(C17_RST_IN);
    else       r_in_q <= w_in;
  end

  c17_comb u_comb (
    .N1  (r_in_q.n1),
    .N2  (r_in_q.n2),
    .N3  (r_in_q.n3),
    .N6  (r_in_q.n6),
    .N7  (r_in_q.n7),
    .N22 (w_n22),
    .N23 (w_n23)
  );

  // Stage 2: register the netlist outputs; reset discards in-flight results.
  always_ff @(posedge clock) begin
    if (reset) r_out <= c17_out_t'(C17_RST_OUT);
    else       r_out <= '{po0: w_n22, po1: w_n23};
  end

  assign bus.po0 = r_out.po0;
  assign bus.po1 = r_out.po1;
endmodule

// File: tb/tb_c17_top.sv
// Scoreboard bench for c17_top: the driver queues the expected output
// for each vector and the monitor compares whenever an entry comes due.
module tb_c17_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  c17_if bus_if();

  c17_top dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  // Previously driven vector; its expectation is finalised once the
  // reset level at the following edge is known.
  logic [1:0] p_exp;
  logic       p_rst;
  string      p_name;
  bit         p_vld = 1'b0;

  // NAND equations of the netlist, v = {N1,N2,N3,N6,N7}; returns {N22,N23}.
  function automatic logic [1:0] c17_ref(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // v = {in0..in4}; e = expected {po0,po1} if no reset intervenes.
  task automatic drive(input logic [4:0] v, input logic r,
                       input logic [1:0] e, input string nm);
    exp_t t;
    @(negedge clk);
    if (p_vld) begin
      t.due  = cyc + 1;
      t.exp  = (p_rst || r) ? 2'b00 : p_exp;
      t.name = p_name;
      sb.push_back(t);
    end else if (r) begin
      t.due  = cyc + 1;
      t.exp  = 2'b00;
      t.name = "rst_first";
      sb.push_back(t);
    end
    bus_if.input_0 = v[4];
    bus_if.input_1 = v[3];
    bus_if.input_2 = v[2];
    bus_if.input_3 = v[1];
    bus_if.input_4 = v[0];
    rst    = r;
    p_exp  = e;
    p_rst  = r;
    p_name = nm;
    p_vld  = 1'b1;
  endtask

  // Monitor: outputs are registered, so sampling at negedge is stable.
  always @(negedge clk) begin : mon
    exp_t       t;
    logic [1:0] got;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      t   = sb.pop_front();
      got = {bus_if.po0, bus_if.po1};
      checks++;
      if (t.due != cyc)
        $display("FAIL %s: entry due at cycle %0d checked at %0d", t.name, t.due, cyc);
      else if (got !== t.exp)
        $display("FAIL %s: got po0,po1=%b expected %b (cycle %0d)", t.name, got, t.exp, cyc);
      else
        passes++;
    end
  end

  initial begin
    bus_if.input_0 = 1'b0;
    bus_if.input_1 = 1'b0;
    bus_if.input_2 = 1'b0;
    bus_if.input_3 = 1'b0;
    bus_if.input_4 = 1'b0;

    // Reset held two cycles with all-ones inputs.
    drive(5'b11111, 1'b1, 2'b00, "rst_a");
    drive(5'b11111, 1'b1, 2'b00, "rst_b");
    // Directed vectors with hand-computed results.
    drive(5'b00000, 1'b0, 2'b00, "zero");
    drive(5'b11111, 1'b0, 2'b10, "ones");
    drive(5'b00101, 1'b0, 2'b01, "v00101");
    drive(5'b01010, 1'b0, 2'b11, "v01010");
    // Exhaustive sweep, one vector per cycle.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = i[4:0];
      drive(v, 1'b0, c17_ref(v), $sformatf("sweep_%0d", i));
    end
    // Reset while 11111 is in flight: its result must be suppressed.
    drive(5'b11111, 1'b0, 2'b10, "inflight");
    drive(5'b11111, 1'b1, 2'b00, "rst_mid");
    drive(5'b00000, 1'b0, 2'b00, "post_rst");
    drive(5'b00000, 1'b0, 2'b00, "flush_a");
    drive(5'b00000, 1'b0, 2'b00, "flush_b");

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries still pending, expected 0", sb.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
